operand_ram_banked: RTL

- Parametrised two-bank operand memory that supplies operand A and operand B in a single cycle.
- Each bank has its own write enable and its own write address.
- Reads are registered and qualified by a valid flag, with selectable read-during-write behaviour.
- A built-in clear sequencer zeroes both banks after reset or on request.
- Sits between the memory controller and the datapath.

---
 rtl/operand_ram_banked_if.sv | 33 +++
 rtl/operand_ram_banked.sv | 109 ++++++++++
 2 files changed

// File: rtl/operand_ram_banked_if.sv
// Operand RAM bus: write ports for banks A/B, shared read request, registered read data.
// The master drives the request side; the slave is the memory itself.
interface operand_ram_banked_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              mem_clr;
    logic              mem_we_opa;
    logic              mem_we_opb;
    logic [ADDR_W-1:0] mem_waddr_opa;
    logic [ADDR_W-1:0] mem_waddr_opb;
    logic [DATA_W-1:0] mem_data_in_opa;
    logic [DATA_W-1:0] mem_data_in_opb;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr_opa;
    logic [ADDR_W-1:0] mem_raddr_opb;
    logic [DATA_W-1:0] mem_data_out_opa;
    logic [DATA_W-1:0] mem_data_out_opb;
    logic              mem_rvalid;
    logic              mem_ready;

    modport master (
        output mem_clr, mem_we_opa, mem_we_opb, mem_waddr_opa, mem_waddr_opb,
               mem_data_in_opa, mem_data_in_opb, mem_re, mem_raddr_opa, mem_raddr_opb,
        input  mem_data_out_opa, mem_data_out_opb, mem_rvalid, mem_ready
    );

    modport slave (
        input  mem_clr, mem_we_opa, mem_we_opb, mem_waddr_opa, mem_waddr_opb,
               mem_data_in_opa, mem_data_in_opb, mem_re, mem_raddr_opa, mem_raddr_opb,
        output mem_data_out_opa, mem_data_out_opb, mem_rvalid, mem_ready
    );
endinterface

// File: rtl/operand_ram_banked.sv
// Two-bank operand RAM (A/B) with a 1-cycle registered read, selectable
// read-during-write behaviour and a clear sweep that zeroes both banks.
module operand_ram_banked #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 6,
    parameter int DEPTH         = 64,
    parameter int READ_MODE     = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                 mem_clk,
    input  logic                 mem_rst_n,
    operand_ram_banked_if.slave  bus
);
    localparam int NUM_BANKS = 2;
    localparam int CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0]  DEPTH_A   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] clr_addr;
    logic             ready;
    logic             rvalid_q;

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q <= (INIT_ON_RESET != 0) ? S_CLEAR : S_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                if (bus.mem_clr) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Gated by the reset pin so ready reads 0 throughout reset, even when no sweep follows.
    assign ready         = (state_q == S_READY) && mem_rst_n;
    assign bus.mem_ready = ready;
    assign clr_addr      = ADDR_W'(cnt_q);

    logic [NUM_BANKS-1:0]             we;
    logic [NUM_BANKS-1:0][ADDR_W-1:0] waddr, raddr;
    logic [NUM_BANKS-1:0][DATA_W-1:0] wdata, rdata;

    assign we    = {bus.mem_we_opb, bus.mem_we_opa};
    assign waddr = {bus.mem_waddr_opb, bus.mem_waddr_opa};
    assign raddr = {bus.mem_raddr_opb, bus.mem_raddr_opa};
    assign wdata = {bus.mem_data_in_opb, bus.mem_data_in_opa};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;
        logic              w_in, r_in, bypass;

        assign w_in   = {1'b0, waddr[b]} < DEPTH_A;
        assign r_in   = {1'b0, raddr[b]} < DEPTH_A;
        assign bypass = (READ_MODE == 0) && we[b] && (waddr[b] == raddr[b]);

        always_ff @(posedge mem_clk) begin
            if (state_q == S_CLEAR)
                mem[clr_addr] <= '0;
            else if (ready && we[b] && w_in)
                mem[waddr[b]] <= wdata[b];
        end

        always_ff @(posedge mem_clk or negedge mem_rst_n) begin
            if (!mem_rst_n)
                rd_q <= '0;
            else if (ready && bus.mem_re)
                rd_q <= !r_in ? '0 : (bypass ? wdata[b] : mem[raddr[b]]);
        end

        assign rdata[b] = rd_q;
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) rvalid_q <= 1'b0;
        else            rvalid_q <= ready && bus.mem_re;
    end

    assign bus.mem_data_out_opa = rdata[0];
    assign bus.mem_data_out_opb = rdata[1];
    assign bus.mem_rvalid       = rvalid_q;
endmodule
